pfm_boot_loader: RTL

- Byte-stream program loader directly upstream of mcu_v2_pipeline.
- Receives a framed program image over a valid/ready byte interface and assembles little-endian 32-bit words.
- Writes the words into the PFM write port, verifies an XOR checksum, and holds the CPU in reset until a good image is loaded.
- Replaces the bench-side PFM preload in system-level tests.

---
 rtl/pkg_boot_utils.sv | 21 ++
 rtl/pfm_boot_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pkg_boot_utils.sv
// Shared types and helpers for the PFM boot loader: frame FSM states,
// the frame sync marker and the checksum step.
package pkg_boot_utils;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } boot_state_t;

    localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;

    function automatic logic [7:0] boot_xor8(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/pfm_boot_loader.sv
// Byte-stream program loader: parses SYNC/LEN/DATA/CHK frames, writes LE words
// into the PFM and releases the CPU from reset once the checksum matches.
module pfm_boot_loader
    import pkg_boot_utils::*;
#(
    parameter int unsigned                  ADDR_BUS_WIDTH  = 32,
    parameter int unsigned                  DATA_BUS_WIDTH  = 32,
    parameter int unsigned                  PFM_DEPTH_WORDS = 1024,
    parameter logic [ADDR_BUS_WIDTH-1:0]    PFM_BASE_ADDR   = '0,
    parameter logic [7:0]                   SYNC_BYTE       = BOOT_SYNC_BYTE
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_data,
    output logic                        rx_ready,
    output logic                        pfm_wr_en,
    output logic [ADDR_BUS_WIDTH-1:0]   pfm_wr_addr,
    output logic [DATA_BUS_WIDTH-1:0]   pfm_wr_data,
    output logic                        cpu_rst_n,
    output logic                        boot_done,
    output logic                        boot_err,
    output logic [15:0]                 words_loaded
);

    localparam logic [15:0] MAX_WORDS = 16'(PFM_DEPTH_WORDS);

    boot_state_t                state_q, state_d;
    logic [7:0]                 len_lo_q, len_lo_d;
    logic [15:0]                len_q, len_d;
    logic [23:0]                word_q, word_d;
    logic [1:0]                 byte_idx_q, byte_idx_d;
    logic [7:0]                 chk_q, chk_d;
    logic [15:0]                words_q, words_d;
    logic                       rx_ready_q, rx_ready_d;
    logic                       wr_en_q, wr_en_d;
    logic [ADDR_BUS_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_BUS_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic                       cpu_rst_n_q, cpu_rst_n_d;
    logic                       boot_done_q, boot_done_d;
    logic                       boot_err_q, boot_err_d;
    logic [15:0]                len_rx;

    assign len_rx = {rx_data, len_lo_q};

    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        len_d       = len_q;
        word_d      = word_q;
        byte_idx_d  = byte_idx_q;
        chk_d       = chk_q;
        words_d     = words_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        cpu_rst_n_d = cpu_rst_n_q;
        boot_done_d = boot_done_q;
        boot_err_d  = boot_err_q;

        if (rx_valid && rx_ready_q) begin
            case (state_q)
                IDLE, ERROR: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d    = LEN_LO;
                        chk_d      = 8'h00;
                        words_d    = 16'h0000;
                        byte_idx_d = 2'd0;
                        boot_err_d = 1'b0;
                    end
                end
                LEN_LO: begin
                    len_lo_d = rx_data;
                    state_d  = LEN_HI;
                end
                LEN_HI: begin
                    len_d = len_rx;
                    if (len_rx > MAX_WORDS) begin
                        state_d    = ERROR;
                        boot_err_d = 1'b1;
                    end else if (len_rx == 16'h0000) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    chk_d      = boot_xor8(chk_q, rx_data);
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        default: begin
                            // Top lane goes straight to the write port; address uses the pre-increment count.
                            wr_en_d   = 1'b1;
                            wr_data_d = DATA_BUS_WIDTH'({rx_data, word_q});
                            wr_addr_d = PFM_BASE_ADDR + ADDR_BUS_WIDTH'({words_q, 2'b00});
                            words_d   = words_q + 16'd1;
                            if (words_d == len_q) begin
                                state_d = CHECK;
                            end
                        end
                    endcase
                end
                CHECK: begin
                    if (rx_data == chk_q) begin
                        state_d     = DONE;
                        cpu_rst_n_d = 1'b1;
                        boot_done_d = 1'b1;
                    end else begin
                        state_d    = ERROR;
                        boot_err_d = 1'b1;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // DONE is terminal, so upstream is stalled from the entry edge onward.
        rx_ready_d = (state_d != DONE);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            len_lo_q    <= 8'h00;
            len_q       <= 16'h0000;
            word_q      <= 24'h000000;
            byte_idx_q  <= 2'd0;
            chk_q       <= 8'h00;
            words_q     <= 16'h0000;
            rx_ready_q  <= 1'b1;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= PFM_BASE_ADDR;
            wr_data_q   <= '0;
            cpu_rst_n_q <= 1'b0;
            boot_done_q <= 1'b0;
            boot_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            word_q      <= word_d;
            byte_idx_q  <= byte_idx_d;
            chk_q       <= chk_d;
            words_q     <= words_d;
            rx_ready_q  <= rx_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            boot_done_q <= boot_done_d;
            boot_err_q  <= boot_err_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign pfm_wr_en    = wr_en_q;
    assign pfm_wr_addr  = wr_addr_q;
    assign pfm_wr_data  = wr_data_q;
    assign cpu_rst_n    = cpu_rst_n_q;
    assign boot_done    = boot_done_q;
    assign boot_err     = boot_err_q;
    assign words_loaded = words_q;

endmodule
